// File: rtl/piso_tx_if.sv
// Parallel-load / serial-out transmitter bus: parallel word and load request in,
// serial line plus frame strobes out.
interface piso_tx_if;
  logic [6:0] i_data_in;
  logic       i_load;
  logic       o_data_out;
  logic       o_start;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_data_in, i_load,
    input  o_data_out, o_start, o_busy, o_done
  );

  modport slave (
    input  i_data_in, i_load,
    output o_data_out, o_start, o_busy, o_done
  );
endinterface

// File: rtl/piso_tx.sv
// 7-bit PISO transmitter: start strobe, then 7 data bits LSB first,
// each period lasting CYCLES_PER_BIT+1 clocks, then a one-clock done pulse.
module piso_tx #(
  parameter int CYCLES_PER_BIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  piso_tx_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CYC = 8'(CYCLES_PER_BIT);

  state_t     state;
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [7:0] cyc_cnt;
  logic       period_end;

  assign period_end = (cyc_cnt == LAST_CYC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      cyc_cnt        <= '0;
      bus.o_data_out <= 1'b0;
      bus.o_start    <= 1'b0;
      bus.o_busy     <= 1'b0;
      bus.o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt        <= '0;
          cyc_cnt        <= '0;
          bus.o_data_out <= 1'b0;
          bus.o_start    <= 1'b0;
          bus.o_busy     <= 1'b0;
          bus.o_done     <= 1'b0;
          if (bus.i_load) begin
            shift_reg   <= bus.i_data_in;
            state       <= START;
            bus.o_start <= 1'b1;
            bus.o_busy  <= 1'b1;
          end
        end
        START: begin
          if (period_end) begin
            cyc_cnt        <= '0;
            state          <= SHIFT;
            bus.o_start    <= 1'b0;
            bus.o_data_out <= shift_reg[0];
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (period_end) begin
            cyc_cnt   <= '0;
            shift_reg <= {1'b0, shift_reg[6:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            // Registered output, so present the bit that becomes shift_reg[0] after this shift.
            if (bit_cnt == 3'd6) begin
              state          <= DONE;
              bus.o_data_out <= 1'b0;
              bus.o_done     <= 1'b1;
            end else begin
              bus.o_data_out <= shift_reg[1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          bit_cnt    <= '0;
          cyc_cnt    <= '0;
          bus.o_done <= 1'b0;
          bus.o_busy <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          bit_cnt        <= '0;
          cyc_cnt        <= '0;
          bus.o_data_out <= 1'b0;
          bus.o_start    <= 1'b0;
          bus.o_busy     <= 1'b0;
          bus.o_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: three instances (CYCLES_PER_BIT 0, 3, 2) compared
// cycle by cycle against a frame waveform model.
module tb_piso_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  piso_tx_if if0();
  piso_tx_if if1();
  piso_tx_if if2();

  piso_tx #(.CYCLES_PER_BIT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  piso_tx #(.CYCLES_PER_BIT(3)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  piso_tx #(.CYCLES_PER_BIT(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  logic [6:0] din;
  logic       load;
  int         sel;

  assign if0.i_data_in = din;
  assign if1.i_data_in = din;
  assign if2.i_data_in = din;
  assign if0.i_load = load && (sel == 0);
  assign if1.i_load = load && (sel == 1);
  assign if2.i_load = load && (sel == 2);

  logic so_d, so_s, so_b, so_n;
  always_comb begin
    so_d = if0.o_data_out; so_s = if0.o_start; so_b = if0.o_busy; so_n = if0.o_done;
    case (sel)
      1: begin so_d = if1.o_data_out; so_s = if1.o_start; so_b = if1.o_busy; so_n = if1.o_done; end
      2: begin so_d = if2.o_data_out; so_s = if2.o_start; so_b = if2.o_busy; so_n = if2.o_done; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;
  logic st [64];
  logic dt [64];
  logic bs [64];
  logic dn [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected {start,busy,done,data} k clocks after the load edge (k=1 is the first).
  function automatic logic [3:0] model(input int k, input int p, input logic [6:0] w);
    if (k >= 1 && k <= p) return 4'b1100;
    if (k > p && k <= 8 * p) return {3'b010, w[(k - p - 1) / p]};
    if (k == 8 * p + 1) return 4'b0110;
    return 4'b0000;
  endfunction

  task automatic run(input int s, input int ncap, input logic [6:0] w,
                     input int poke_k, input logic [6:0] poke_d, input bit keep);
    @(negedge clk);
    sel = s; din = w; load = 1'b1;
    for (int k = 1; k <= ncap; k++) begin
      @(negedge clk);
      st[k] = so_s; dt[k] = so_d; bs[k] = so_b; dn[k] = so_n;
      if (!keep) load = 1'b0;
      if (k == poke_k) begin din = poke_d; load = 1'b1; end
    end
    load = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int p, input logic [6:0] w, input int k0);
    int ns, nb, nd, mis, idx;
    logic [6:0] rx;
    ns = 0; nb = 0; nd = 0; mis = 0; rx = '0;
    for (int j = 0; j <= 8 * p + 1; j++) begin
      idx = k0 + j;
      ns += int'(st[idx]); nb += int'(bs[idx]); nd += int'(dn[idx]);
      if ({st[idx], bs[idx], dn[idx], dt[idx]} !== model(j + 1, p, w)) mis++;
    end
    for (int b = 0; b < 7; b++) rx[b] = dt[k0 - 1 + p + 1 + b * p + p / 2];
    check({tag, " start_clks"}, ns, p);
    check({tag, " busy_clks"}, nb, 8 * p + 1);
    check({tag, " done_pulses"}, nd, 1);
    check({tag, " rx_word"}, {25'd0, rx}, {25'd0, w});
    check({tag, " wave_mismatch"}, mis, 0);
  endtask

  initial begin
    int nb, nd;
    din = '0; load = 1'b0; sel = 0;

    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("rst data_out", so_d, 0);
      check("rst start", so_s, 0);
      check("rst busy", so_b, 0);
      check("rst done", so_n, 0);
    end
    @(negedge clk); reset = 1'b0;

    run(0, 10, 7'h55, 0, 7'h00, 1'b0);
    check_frame("p1_55", 1, 7'h55, 1);

    run(1, 36, 7'h01, 0, 7'h00, 1'b0);
    check_frame("p4_01", 4, 7'h01, 1);

    run(0, 14, 7'h7F, 4, 7'h00, 1'b0);
    check_frame("midload_7f", 1, 7'h7F, 1);
    nb = 0; nd = 0;
    for (int k = 1; k <= 14; k++) begin nb += int'(bs[k]); nd += int'(dn[k]); end
    check("midload total_busy", nb, 9);
    check("midload total_done", nd, 1);

    run(0, 20, 7'h2A, 2, 7'h15, 1'b1);
    check_frame("b2b_2a", 1, 7'h2A, 1);
    check("b2b gap_idle", bs[10], 0);
    check_frame("b2b_15", 1, 7'h15, 11);

    // Abort in the middle of data bit 3 (value 1) with an asynchronous reset.
    @(negedge clk);
    sel = 2; din = 7'h5A; load = 1'b1;
    repeat (14) begin @(negedge clk); load = 1'b0; end
    check("abort pre data", so_d, 1);
    check("abort pre busy", so_b, 1);
    #2 reset = 1'b1;
    #1;
    check("abort data_out", so_d, 0);
    check("abort start", so_s, 0);
    check("abort busy", so_b, 0);
    check("abort done", so_n, 0);
    nd = 0;
    repeat (3) begin @(negedge clk); nd += int'(so_n); end
    reset = 1'b0;
    @(negedge clk); nd += int'(so_n);
    check("abort no_done", nd, 0);
    check("abort idle_busy", so_b, 0);
    run(2, 27, 7'h33, 0, 7'h00, 1'b0);
    check_frame("p3_33", 3, 7'h33, 1);

    for (int w = 0; w < 128; w++) begin
      run(0, 10, 7'(w), 0, 7'h00, 1'b0);
      check_frame("loopback", 1, 7'(w), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
